// File: rtl/instruction_dispatcher.sv
// instruction_dispatcher: front end of the memory controller. Takes 32-bit
// instruction words from the HPS bridge, validates them, tracks the zoom level,
// runs the enable/done handshake with the controller and reports status.
//
// Handshakes:
//   instr_valid/instr_ready - a word transfers on the rising edge where both are
//   high; instr_ready stays low from that edge until the cycle after cmd_done,
//   and instr_valid offered meanwhile is ignored.
//   mc_enable/mc_done - mc_enable pulses for one cycle only while mc_done is
//   high; the controller acknowledges by dropping mc_done, and completion is
//   mc_done rising again.
module instruction_dispatcher #(
    parameter int         MAX_ADDR    = 76799,
    parameter int         ACK_TIMEOUT = 8,
    parameter logic [2:0] ZOOM_RESET  = 3'b010,
    parameter logic [2:0] ZOOM_MAX    = 3'b100,
    parameter logic [2:0] ZOOM_MIN    = 3'b000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [2:0]  mc_operation,
    output logic [16:0] mc_addr_base,
    output logic [7:0]  mc_color,
    output logic        mc_enable,
    output logic [2:0]  mc_zoom,
    input  logic        mc_done,
    input  logic [7:0]  mc_color_rd,
    output logic [7:0]  rd_data,
    output logic        cmd_done,
    output logic        busy,
    output logic        error,
    output logic [1:0]  error_code,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DECODE    = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_ACK  = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_COMPLETE  = 3'd5
    } state_t;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_READ  = 3'b001;
    localparam logic [2:0] OP_WRITE = 3'b010;
    localparam logic [2:0] OP_NHI   = 3'b011;
    localparam logic [2:0] OP_PR    = 3'b100;
    localparam logic [2:0] OP_NH    = 3'b101;
    localparam logic [2:0] OP_BA    = 3'b110;
    localparam logic [2:0] OP_ILL   = 3'b111;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_OPCODE  = 2'b01;
    localparam logic [1:0] ERR_RANGE   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam int              CNT_W      = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [16:0]     MAX_ADDR_V = 17'(MAX_ADDR);

    state_t            state_q, state_d;
    logic [27:0]       instr_q, instr_d;
    logic [CNT_W-1:0]  ack_cnt_q, ack_cnt_d;
    logic              instr_ready_q, instr_ready_d;
    logic [2:0]        mc_operation_q, mc_operation_d;
    logic [16:0]       mc_addr_base_q, mc_addr_base_d;
    logic [7:0]        mc_color_q, mc_color_d;
    logic [2:0]        mc_zoom_q, mc_zoom_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic              cmd_done_q, cmd_done_d;
    logic              busy_q, busy_d;
    logic              error_q, error_d;
    logic [1:0]        error_code_q, error_code_d;
    logic              mc_enable_c;

    // Bits [31:28] of the instruction word carry nothing.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[31:28];

    // Fields of the latched instruction and the decode-time checks on them.
    logic [2:0]  op;
    logic [16:0] addr;
    logic [7:0]  color;
    logic        is_rw, is_zin, is_zout, range_bad, reject, take;

    assign op        = instr_q[2:0];
    assign addr      = instr_q[19:3];
    assign color     = instr_q[27:20];
    assign is_rw     = (op == OP_READ) || (op == OP_WRITE);
    assign is_zin    = (op == OP_NHI) || (op == OP_PR);
    assign is_zout   = (op == OP_NH) || (op == OP_BA);
    assign range_bad = (is_rw && (addr > MAX_ADDR_V)) ||
                       (is_zin && (mc_zoom_q == ZOOM_MAX)) ||
                       (is_zout && (mc_zoom_q == ZOOM_MIN));
    assign reject    = (op == OP_ILL) || range_bad;
    assign take      = instr_valid && instr_ready_q;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (take) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (reject || (op == OP_NOP)) state_d = S_COMPLETE;
                else                          state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (mc_done) state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (!mc_done)                   state_d = S_WAIT_DONE;
                else if (ack_cnt_q == ACK_LAST) state_d = S_COMPLETE;
            end
            S_WAIT_DONE: begin
                if (mc_done) state_d = S_COMPLETE;
            end
            S_COMPLETE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values; busy/instr_ready release the cycle after cmd_done.
    always_comb begin
        instr_d        = instr_q;
        ack_cnt_d      = ack_cnt_q;
        instr_ready_d  = instr_ready_q;
        mc_operation_d = mc_operation_q;
        mc_addr_base_d = mc_addr_base_q;
        mc_color_d     = mc_color_q;
        mc_zoom_d      = mc_zoom_q;
        rd_data_d      = rd_data_q;
        cmd_done_d     = 1'b0;
        busy_d         = busy_q;
        error_d        = error_q;
        error_code_d   = error_code_q;
        mc_enable_c    = 1'b0;

        if (cmd_done_q) begin
            busy_d        = 1'b0;
            instr_ready_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (take) begin
                    instr_d       = instr[27:0];
                    error_d       = 1'b0;
                    error_code_d  = ERR_NONE;
                    busy_d        = 1'b1;
                    instr_ready_d = 1'b0;
                end
            end
            S_DECODE: begin
                if (op == OP_ILL) begin
                    error_d      = 1'b1;
                    error_code_d = ERR_OPCODE;
                end else if (range_bad) begin
                    error_d      = 1'b1;
                    error_code_d = ERR_RANGE;
                end else if (op != OP_NOP) begin
                    mc_operation_d = op;
                    mc_addr_base_d = addr;
                    mc_color_d     = color;
                end
            end
            S_ISSUE: begin
                if (mc_done) begin
                    mc_enable_c = 1'b1;
                    ack_cnt_d   = '0;
                end
            end
            S_WAIT_ACK: begin
                if (mc_done) begin
                    if (ack_cnt_q == ACK_LAST) begin
                        error_d      = 1'b1;
                        error_code_d = ERR_TIMEOUT;
                    end else begin
                        ack_cnt_d = ack_cnt_q + 1'b1;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (mc_done) begin
                    if (op == OP_READ) rd_data_d = mc_color_rd;
                    if (is_zin)        mc_zoom_d = mc_zoom_q + 3'd1;
                    if (is_zout)       mc_zoom_d = mc_zoom_q - 3'd1;
                end
            end
            S_COMPLETE: begin
                cmd_done_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath and status registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            instr_q        <= '0;
            ack_cnt_q      <= '0;
            instr_ready_q  <= 1'b1;
            mc_operation_q <= '0;
            mc_addr_base_q <= '0;
            mc_color_q     <= '0;
            mc_zoom_q      <= ZOOM_RESET;
            rd_data_q      <= '0;
            cmd_done_q     <= 1'b0;
            busy_q         <= 1'b0;
            error_q        <= 1'b0;
            error_code_q   <= ERR_NONE;
        end else begin
            instr_q        <= instr_d;
            ack_cnt_q      <= ack_cnt_d;
            instr_ready_q  <= instr_ready_d;
            mc_operation_q <= mc_operation_d;
            mc_addr_base_q <= mc_addr_base_d;
            mc_color_q     <= mc_color_d;
            mc_zoom_q      <= mc_zoom_d;
            rd_data_q      <= rd_data_d;
            cmd_done_q     <= cmd_done_d;
            busy_q         <= busy_d;
            error_q        <= error_d;
            error_code_q   <= error_code_d;
        end
    end

    assign instr_ready  = instr_ready_q;
    assign mc_operation = mc_operation_q;
    assign mc_addr_base = mc_addr_base_q;
    assign mc_color     = mc_color_q;
    assign mc_enable    = mc_enable_c;
    assign mc_zoom      = mc_zoom_q;
    assign rd_data      = rd_data_q;
    assign cmd_done     = cmd_done_q;
    assign busy         = busy_q;
    assign error        = error_q;
    assign error_code   = error_code_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_instruction_dispatcher.sv
// Bench for instruction_dispatcher: directed instruction sequence against a small
// registered controller model; completions are checked by a scoreboard monitor.
module tb_instruction_dispatcher;

    // ---------------- clock / reset ----------------
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        mc_done = 1'b1;
    logic [7:0]  mc_color_rd = '0;

    logic        instr_ready;
    logic [2:0]  mc_operation;
    logic [16:0] mc_addr_base;
    logic [7:0]  mc_color;
    logic        mc_enable;
    logic [2:0]  mc_zoom;
    logic [7:0]  rd_data;
    logic        cmd_done;
    logic        busy;
    logic        error;
    logic [1:0]  error_code;
    logic [2:0]  state_dbg;

    always #5 clock = ~clock;

    instruction_dispatcher dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .mc_operation (mc_operation),
        .mc_addr_base (mc_addr_base),
        .mc_color     (mc_color),
        .mc_enable    (mc_enable),
        .mc_zoom      (mc_zoom),
        .mc_done      (mc_done),
        .mc_color_rd  (mc_color_rd),
        .rd_data      (rd_data),
        .cmd_done     (cmd_done),
        .busy         (busy),
        .error        (error),
        .error_code   (error_code),
        .state_dbg    (state_dbg)
    );

    int total = 0;
    int bad   = 0;
    logic [21:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // ---------------- controller model ----------------
    int          en_count = 0;
    logic [2:0]  en_op = '0;
    logic [16:0] en_addr = '0;
    logic [7:0]  en_color = '0;
    int          busy_len = 2;
    int          busy_cnt = 0;
    logic        stuck = 1'b0;
    int          wack_cycles = 0;

    always @(posedge clock) begin
        if (mc_enable) begin
            en_count <= en_count + 1;
            en_op    <= mc_operation;
            en_addr  <= mc_addr_base;
            en_color <= mc_color;
        end
        if (mc_enable && !stuck) begin
            mc_done  <= 1'b0;
            busy_cnt <= busy_len;
        end else if (!mc_done) begin
            if (busy_cnt <= 1) mc_done <= 1'b1;
            else               busy_cnt <= busy_cnt - 1;
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clock) begin
        logic [21:0] e;
        if (state_dbg == 3'd3) wack_cycles++;
        if (reset_n && cmd_done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_cmd_done got=1 exp=0");
            end else begin
                e = exp_q.pop_front();
                check("completion{en,zoom,rd,err,code}",
                      {en_count[7:0], mc_zoom, rd_data, error, error_code}, e);
            end
        end
    end

    // ---------------- driver helpers ----------------
    function automatic logic [31:0] mk(input logic [2:0] op, input logic [16:0] a, input logic [7:0] c);
        return {4'hF, c, a, op};
    endfunction

    function automatic logic [21:0] ex(input int en, input logic [2:0] z, input logic [7:0] rd,
                                       input logic [1:0] code);
        logic [7:0] en8;
        en8 = 8'(en);
        return {en8, z, rd, (code != 2'b00), code};
    endfunction

    // lat counts the accept cycle as 0; bcyc counts cycles with busy high.
    task automatic issue(input logic [31:0] word, input logic [21:0] exp, output int lat, output int bcyc);
        int guard;
        guard = 0;
        lat   = 0;
        bcyc  = 0;
        while (!instr_ready && guard < 100) begin
            @(posedge clock); #1;
            guard++;
        end
        check("ready_before_issue", 32'(instr_ready), 32'd1);
        exp_q.push_back(exp);
        instr       = word;
        instr_valid = 1'b1;
        @(posedge clock); #1;
        instr_valid = 1'b0;
        lat = 1;
        if (busy) bcyc++;
        while (!cmd_done && lat < 300) begin
            @(posedge clock); #1;
            lat++;
            if (busy) bcyc++;
        end
        @(posedge clock); #1;
        if (busy) bcyc++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_instr_ready"}, 32'(instr_ready), 32'd1);
        check({tag, "_mc_enable"}, 32'(mc_enable), 32'd0);
        check({tag, "_mc_operation"}, 32'(mc_operation), 32'd0);
        check({tag, "_mc_addr_base"}, 32'(mc_addr_base), 32'd0);
        check({tag, "_mc_color"}, 32'(mc_color), 32'd0);
        check({tag, "_mc_zoom"}, 32'(mc_zoom), 32'd2);
        check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
        check({tag, "_cmd_done"}, 32'(cmd_done), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_error_code"}, 32'(error_code), 32'd0);
        check({tag, "_state"}, 32'(state_dbg), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int lat, bcyc, w0, guard;

        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("in_reset");
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock); #1;
        check_reset_outputs("after_reset");

        // READ 100, controller returns A5
        mc_color_rd = 8'hA5;
        issue(mk(3'b001, 17'd100, 8'h00), ex(1, 3'd2, 8'hA5, 2'b00), lat, bcyc);
        check("read_latency", lat, 7);
        check("read_op", 32'(en_op), 32'd1);
        check("read_addr", 32'(en_addr), 32'd100);

        // WRITE beyond last pixel: rejected, error sticky until next accept
        issue(mk(3'b010, 17'd76800, 8'h3C), ex(1, 3'd2, 8'hA5, 2'b10), lat, bcyc);
        check("oob_latency", lat, 3);
        @(posedge clock); #1;
        check("oob_error_sticky", 32'(error), 32'd1);
        check("oob_code_sticky", 32'(error_code), 32'd2);

        // NOP clears the error
        issue(mk(3'b000, 17'd0, 8'h00), ex(1, 3'd2, 8'hA5, 2'b00), lat, bcyc);
        check("nop_latency", lat, 3);

        // WRITE at the last legal pixel
        issue(mk(3'b010, 17'd76799, 8'h5A), ex(2, 3'd2, 8'hA5, 2'b00), lat, bcyc);
        check("write_latency", lat, 7);
        check("write_op", 32'(en_op), 32'd2);
        check("write_addr", 32'(en_addr), 32'd76799);
        check("write_color", 32'(en_color), 32'h5A);

        // Illegal opcode
        issue(mk(3'b111, 17'd5, 8'h00), ex(2, 3'd2, 8'hA5, 2'b01), lat, bcyc);
        check("ill_latency", lat, 3);
        check("ill_busy_cycles", bcyc, 3);

        // Zoom in to the top, then one too many
        issue(mk(3'b011, 17'd0, 8'h00), ex(3, 3'd3, 8'hA5, 2'b00), lat, bcyc);
        issue(mk(3'b011, 17'd0, 8'h00), ex(4, 3'd4, 8'hA5, 2'b00), lat, bcyc);
        issue(mk(3'b011, 17'd0, 8'h00), ex(4, 3'd4, 8'hA5, 2'b10), lat, bcyc);
        check("zoom_max_reject_latency", lat, 3);

        // Zoom out to the bottom, then a BA at the floor
        issue(mk(3'b101, 17'd0, 8'h00), ex(5, 3'd3, 8'hA5, 2'b00), lat, bcyc);
        issue(mk(3'b101, 17'd0, 8'h00), ex(6, 3'd2, 8'hA5, 2'b00), lat, bcyc);
        issue(mk(3'b101, 17'd0, 8'h00), ex(7, 3'd1, 8'hA5, 2'b00), lat, bcyc);
        issue(mk(3'b101, 17'd0, 8'h00), ex(8, 3'd0, 8'hA5, 2'b00), lat, bcyc);
        issue(mk(3'b110, 17'd0, 8'h00), ex(8, 3'd0, 8'hA5, 2'b10), lat, bcyc);

        // Controller never acknowledges: timeout, zoom unchanged
        stuck = 1'b1;
        w0 = wack_cycles;
        issue(mk(3'b100, 17'd0, 8'h00), ex(9, 3'd0, 8'hA5, 2'b11), lat, bcyc);
        check("wait_ack_cycles", wack_cycles - w0, 8);
        check("timeout_latency", lat, 12);
        stuck = 1'b0;

        // Reset during WAIT_DONE of a PR: abort, no completion
        busy_len    = 20;
        instr       = mk(3'b100, 17'd0, 8'h00);
        instr_valid = 1'b1;
        @(posedge clock); #1;
        instr_valid = 1'b0;
        guard = 0;
        while (state_dbg != 3'd4 && guard < 40) begin
            @(posedge clock); #1;
            guard++;
        end
        check("reached_wait_done", 32'(state_dbg), 32'd4);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        repeat (2) @(posedge clock);
        @(negedge clock) reset_n = 1'b1;
        repeat (30) @(posedge clock);
        #1;
        check("ready_after_abort", 32'(instr_ready), 32'd1);
        check("zoom_after_abort", 32'(mc_zoom), 32'd2);

        // Normal READ after the abort
        busy_len    = 2;
        mc_color_rd = 8'h11;
        issue(mk(3'b001, 17'd0, 8'h00), ex(11, 3'd2, 8'h11, 2'b00), lat, bcyc);
        check("read2_latency", lat, 7);
        check("read2_addr", 32'(en_addr), 32'd0);

        repeat (3) @(posedge clock);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
